// File: rtl/pulse_period_meter_if.sv
// rtl/pulse_period_meter_if.sv - tick input, enable and period result bundle for pulse_period_meter
//
// Signals:
//   en           measurement enable; low forces the meter idle
//   pulse_in     tick to be measured; only rising edges count
//   period       last captured period in clk cycles (CW bits)
//   period_valid period holds an unacknowledged result
//   period_ack   consumer acknowledge; clears period_valid
//   overrun      sticky; a result was dropped while period_valid was high
//   timeout      one-cycle pulse; no edge within MAX_PERIOD cycles
//   busy         meter is armed or measuring
// Modports: master drives en/pulse_in/period_ack, slave is the meter.
interface pulse_period_meter_if #(
    parameter int MAX_PERIOD = 20000000
);
    localparam int CW = $clog2(MAX_PERIOD + 1);

    logic          en;
    logic          pulse_in;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          period_ack;
    logic          overrun;
    logic          timeout;
    logic          busy;

    modport master (
        output en, pulse_in, period_ack,
        input  period, period_valid, overrun, timeout, busy
    );

    modport slave (
        input  en, pulse_in, period_ack,
        output period, period_valid, overrun, timeout, busy
    );
endinterface

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures clk cycles between successive rising edges of a tick
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  pulse_period_meter_if.slave: en, pulse_in, period_ack in;
//        period, period_valid, overrun, timeout, busy out
// Build option: define PERIOD_METER_SYNC_EN to pass pulse_in through a
// two-flop synchronizer before edge detection (adds 2 cycles of latency).
module pulse_period_meter #(
    parameter int MAX_PERIOD = 20000000
) (
    input  logic                clk,
    input  logic                rst,
    pulse_period_meter_if.slave bus
);
    localparam int CW = $clog2(MAX_PERIOD + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PERIOD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] period_q;
    logic          prev_q;
    logic          valid_q;
    logic          overrun_q;
    logic          timeout_q;
    logic          busy_q;

    logic pulse_s;
    logic pulse_edge;
    logic capture;

`ifdef PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.pulse_in};
        end
    end

    assign pulse_s = sync_q[1];
`else
    assign pulse_s = bus.pulse_in;
`endif

    // prev tracks the tick even while disabled, so a tick already high
    // when en rises is not mistaken for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= pulse_s;
        end
    end

    assign pulse_edge = pulse_s & ~prev_q;
    assign capture    = bus.en && (state_q == MEASURE) && pulse_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (!bus.en) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            // Every enabled state leads to ARMED or MEASURE next.
            busy_q    <= 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    state_q <= ARMED;
                end
                ARMED: begin
                    if (pulse_edge) begin
                        cnt_q   <= CW'(1);
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge landing on cnt==MAX_PERIOD is a capture, so
                    // the edge test takes priority over the timeout.
                    if (pulse_edge) begin
                        cnt_q <= CW'(1);
                    end else if (cnt_q == MAX_CNT) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ARMED;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Result register and valid/ack handshake; retained across en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (capture) begin
            if (!valid_q || bus.period_ack) begin
                period_q <= cnt_q;
                valid_q  <= 1'b1;
                if (valid_q) begin
                    overrun_q <= 1'b0;
                end
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (bus.period_ack && valid_q) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign bus.period       = period_q;
    assign bus.period_valid = valid_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout      = timeout_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - self-checking bench for pulse_period_meter
module tb_pulse_period_meter;
    localparam int MAXP = 20;
`ifdef PERIOD_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    int   cyc_n;
    int   exp_q[$];
    int   exp_cyc_q[$];

    pulse_period_meter_if #(.MAX_PERIOD(MAXP)) bus ();

    pulse_period_meter #(.MAX_PERIOD(MAXP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_period(input int len);
        bus.pulse_in = 1'b1;
        cyc();
        bus.pulse_in = 1'b0;
        repeat (len - 1) cyc();
    endtask

    task automatic test_reset();
        total_cnt++;
        if (bus.period !== 0) $display("FAIL reset_period got=%0d exp=0", bus.period); else pass_cnt++;
        total_cnt++;
        if (bus.period_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.period_valid); else pass_cnt++;
        total_cnt++;
        if (bus.overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", bus.overrun); else pass_cnt++;
        total_cnt++;
        if (bus.timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", bus.timeout); else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.busy); else pass_cnt++;
    endtask

    task automatic test_basic();
        int e;
        int ec;
        logic saw_to;
        saw_to = 1'b0;
        bus.en = 1'b1;
        bus.period_ack = 1'b1;
        bus.pulse_in = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 62 + LAT; i++) begin
            bus.pulse_in = (i < 60) && (i % 10 == 0);
            cyc();
            // No result is expected for the first edge: it only arms.
            if (bus.pulse_in && i > 0) begin
                exp_q.push_back(10);
                exp_cyc_q.push_back(cyc_n + LAT);
            end
            saw_to |= bus.timeout;
            if (bus.period_valid === 1'b1) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL basic_unexpected_valid period=%0d cycle=%0d", bus.period, cyc_n);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    if (bus.period !== e || cyc_n != ec)
                        $display("FAIL basic_result got period=%0d cycle=%0d exp period=%0d cycle=%0d",
                                 bus.period, cyc_n, e, ec);
                    else pass_cnt++;
                end
            end
        end
        bus.pulse_in = 1'b0;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL basic_missing got=%0d pending exp=0", exp_q.size()); else pass_cnt++;
        total_cnt++;
        if (saw_to !== 1'b0) $display("FAIL basic_timeout got=%b exp=0", saw_to); else pass_cnt++;
        exp_q.delete();
        exp_cyc_q.delete();
        bus.en = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_handshake();
        bus.en = 1'b1;
        bus.period_ack = 1'b0;
        cyc();
        run_period(10);
        run_period(10);
        total_cnt++;
        if (bus.period_valid !== 1'b1 || bus.period !== 10 || bus.overrun !== 1'b0)
            $display("FAIL hs_first got v=%b p=%0d o=%b exp v=1 p=10 o=0", bus.period_valid, bus.period, bus.overrun);
        else pass_cnt++;
        run_period(10);
        total_cnt++;
        if (bus.period_valid !== 1'b1 || bus.period !== 10 || bus.overrun !== 1'b1)
            $display("FAIL hs_overrun got v=%b p=%0d o=%b exp v=1 p=10 o=1", bus.period_valid, bus.period, bus.overrun);
        else pass_cnt++;
        bus.period_ack = 1'b1;
        cyc();
        bus.period_ack = 1'b0;
        total_cnt++;
        if (bus.period_valid !== 1'b0 || bus.overrun !== 1'b0)
            $display("FAIL hs_ack got v=%b o=%b exp v=0 o=0", bus.period_valid, bus.overrun);
        else pass_cnt++;
        run_period(9);
        total_cnt++;
        if (bus.period_valid !== 1'b1 || bus.period !== 11 || bus.overrun !== 1'b0)
            $display("FAIL hs_second got v=%b p=%0d o=%b exp v=1 p=11 o=0", bus.period_valid, bus.period, bus.overrun);
        else pass_cnt++;
        run_period(9);
        total_cnt++;
        if (bus.period !== 11 || bus.overrun !== 1'b1)
            $display("FAIL hs_overrun2 got p=%0d o=%b exp p=11 o=1", bus.period, bus.overrun);
        else pass_cnt++;
        // Acknowledge on the very edge that captures the next result.
        for (int i = 0; i <= LAT; i++) begin
            bus.pulse_in = (i == 0);
            bus.period_ack = (i == LAT);
            cyc();
        end
        bus.pulse_in = 1'b0;
        bus.period_ack = 1'b0;
        total_cnt++;
        if (bus.period_valid !== 1'b1 || bus.period !== 9 || bus.overrun !== 1'b0)
            $display("FAIL hs_ack_capture got v=%b p=%0d o=%b exp v=1 p=9 o=0", bus.period_valid, bus.period, bus.overrun);
        else pass_cnt++;
        bus.en = 1'b0;
        bus.period_ack = 1'b1;
        cyc();
        cyc();
        bus.period_ack = 1'b0;
    endtask

    task automatic test_timeout();
        logic bad;
        bad = 1'b0;
        bus.en = 1'b1;
        bus.period_ack = 1'b1;
        cyc();
        bus.pulse_in = 1'b1;
        cyc();
        bus.pulse_in = 1'b0;
        for (int i = 0; i < 19 + LAT; i++) begin
            cyc();
            bad |= bus.timeout;
        end
        total_cnt++;
        if (bad !== 1'b0) $display("FAIL to_early got=%b exp=0", bad); else pass_cnt++;
        cyc();
        total_cnt++;
        if (bus.timeout !== 1'b1) $display("FAIL to_pulse got=%b exp=1", bus.timeout); else pass_cnt++;
        cyc();
        total_cnt++;
        if (bus.timeout !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL to_after got to=%b busy=%b exp to=0 busy=1", bus.timeout, bus.busy);
        else pass_cnt++;
        run_period(7);
        bus.pulse_in = 1'b1;
        cyc();
        bus.pulse_in = 1'b0;
        repeat (LAT) cyc();
        total_cnt++;
        if (bus.period_valid !== 1'b1 || bus.period !== 7)
            $display("FAIL to_rearm got v=%b p=%0d exp v=1 p=7", bus.period_valid, bus.period);
        else pass_cnt++;
        bad = 1'b0;
        for (int i = 0; i < 19 - LAT; i++) begin
            cyc();
            bad |= bus.timeout;
        end
        bus.pulse_in = 1'b1;
        cyc();
        bad |= bus.timeout;
        bus.pulse_in = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            cyc();
            bad |= bus.timeout;
        end
        total_cnt++;
        if (bus.period_valid !== 1'b1 || bus.period !== MAXP || bad !== 1'b0)
            $display("FAIL to_boundary got v=%b p=%0d to=%b exp v=1 p=%0d to=0", bus.period_valid, bus.period, bad, MAXP);
        else pass_cnt++;
        cyc();
        total_cnt++;
        if (bus.timeout !== 1'b0) $display("FAIL to_boundary_after got=%b exp=0", bus.timeout); else pass_cnt++;
    endtask

    task automatic test_enable();
        bus.en = 1'b0;
        cyc();
        bus.en = 1'b1;
        bus.period_ack = 1'b0;
        cyc();
        run_period(10);
        run_period(10);
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL en_busy_meas got=%b exp=1", bus.busy); else pass_cnt++;
        bus.en = 1'b0;
        cyc();
        total_cnt++;
        if (bus.busy !== 1'b0 || bus.period_valid !== 1'b1 || bus.period !== 10)
            $display("FAIL en_drop got busy=%b v=%b p=%0d exp busy=0 v=1 p=10", bus.busy, bus.period_valid, bus.period);
        else pass_cnt++;
        bus.period_ack = 1'b1;
        cyc();
        bus.period_ack = 1'b0;
        bus.pulse_in = 1'b1;
        repeat (LAT + 2) cyc();
        bus.en = 1'b1;
        repeat (5) cyc();
        bus.pulse_in = 1'b0;
        cyc();
        run_period(7);
        total_cnt++;
        if (bus.period_valid !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL en_arm_only got v=%b busy=%b exp v=0 busy=1", bus.period_valid, bus.busy);
        else pass_cnt++;
        bus.pulse_in = 1'b1;
        cyc();
        bus.pulse_in = 1'b0;
        repeat (LAT) cyc();
        total_cnt++;
        if (bus.period_valid !== 1'b1 || bus.period !== 7)
            $display("FAIL en_true_edge got v=%b p=%0d exp v=1 p=7", bus.period_valid, bus.period);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        run_period(5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (bus.period !== 0 || bus.period_valid !== 1'b0 || bus.overrun !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL arst_clear got p=%0d v=%b o=%b to=%b busy=%b exp all 0",
                     bus.period, bus.period_valid, bus.overrun, bus.timeout, bus.busy);
        else pass_cnt++;
        cyc();
        rst = 1'b0;
        cyc();
        run_period(10);
        total_cnt++;
        if (bus.period_valid !== 1'b0) $display("FAIL arst_first_edge got v=%b exp=0", bus.period_valid); else pass_cnt++;
        bus.pulse_in = 1'b1;
        cyc();
        bus.pulse_in = 1'b0;
        repeat (LAT) cyc();
        total_cnt++;
        if (bus.period_valid !== 1'b1 || bus.period !== 10)
            $display("FAIL arst_second_edge got v=%b p=%0d exp v=1 p=10", bus.period_valid, bus.period);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        cyc_n = 0;
        rst = 1'b1;
        bus.en = 1'b0;
        bus.pulse_in = 1'b0;
        bus.period_ack = 1'b0;
        cyc();
        cyc();
        test_reset();
        rst = 1'b0;
        cyc();
        test_basic();
        test_handshake();
        test_timeout();
        test_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
